hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with a memory-wait timeout and a debug halt state.
// Define HAZARD_PERF_CNT_EN to build the stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_rd,
   input  logic [4:0]       ex_rd,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume_req,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       state,
   output logic             timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_HALT = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_d;
   logic        load_use, mem_stall, stalled, wait_hit;
   logic [16:0] stall_num;

   assign load_use  = ex_mem_rd && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   assign mem_stall = mem_req && !mem_ready;
   // Once in WAIT the access is already outstanding, so only mem_ready ends the stall.
   assign stalled   = (state_q == ST_RUN) ? mem_stall : !mem_ready;
   // stall_num is the 1-based index of the current stalled cycle.
   assign stall_num = {1'b0, wait_cnt_q} + 17'd1;
   assign wait_hit  = (stall_num >= 17'(WAIT_TIMEOUT));

   always_comb begin
      // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout;
      if (!rst) begin
         unique case (state_q)
            ST_RUN, ST_WAIT: begin
               if (stalled) begin
                  if (wait_hit) begin
                     timeout_d  = 1'b1;
                     state_d    = ST_HALT;
                     wait_cnt_d = '0;
                  end else begin
                     state_d    = ST_WAIT;
                     wait_cnt_d = stall_num[15:0];
                  end
               end else begin
                  wait_cnt_d = '0;
                  state_d    = (state_q == ST_RUN && halt_req) ? ST_HALT : ST_RUN;
                  if (br_taken) begin
                     {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
                     if_id_flush = 1'b1;
                     id_ex_flush = 1'b1;
                  end else if (load_use) begin
                     id_ex_en    = 1'b1;
                     id_ex_flush = 1'b1;
                     ex_mem_en   = 1'b1;
                  end else begin
                     {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
                  end
               end
            end
            ST_HALT: begin
               wait_cnt_d = '0;
               if (resume_req && !timeout) state_d = ST_RUN;
            end
            ST_BAD: begin
               wait_cnt_d = '0;
               state_d    = ST_RUN;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= '0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout    <= timeout_d;
      end
   end

   assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             stall_evt;

   assign stall_evt = !pc_en && (state_q == ST_RUN || state_q == ST_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
         if (if_id_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
